// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Round-robin arbiter and transaction sequencer. It shares one SPI_Master host-bus
// port among NREQ requesters. Each grant runs one byte transfer:
//   write ctrl -> write txdata -> settle -> poll status[0] -> read rxdata -> done.
// Optional feature macro: SPI_ARB_TIMEOUT_EN. When it is defined, polling is bounded
// to TIMEOUT_CYC cycles and an abort is flagged with err. When it is undefined,
// polling is unbounded and err is tied low.
module spi_master_arbiter #(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              pro_clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_cfg,
    input  logic [8*NREQ-1:0] req_txdata,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic [7:0]        rxdata,
    output logic              err,
    output logic              busy,
    output logic              CS,
    output logic              WR,
    output logic              RD,
    output logic [1:0]        addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(SETTLE_CYC + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WCTL   = 4'd1;
    localparam logic [3:0] S_WTX    = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_PRD1   = 4'd4;
    localparam logic [3:0] S_PRD2   = 4'd5;
    localparam logic [3:0] S_PGAP   = 4'd6;
    localparam logic [3:0] S_RRD1   = 4'd7;
    localparam logic [3:0] S_RRD2   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    logic [3:0]      state_reg, state_next;
    logic [CW-1:0]   settle_reg, settle_next;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   idx_reg;
    logic [7:0]      tx_reg;
    logic [NREQ-1:0] gnt_reg;
    logic            done_reg;
    logic            busy_reg;
    logic [7:0]      rxdata_reg;
    logic            cs_reg, wr_reg, rd_reg;
    logic [1:0]      addr_reg;
    logic [7:0]      wdata_reg;

    logic            cs_next, wr_next, rd_next;
    logic [1:0]      addr_next;
    logic [7:0]      wdata_next;

    logic [IW-1:0]   sel_idx;
    logic            sel_hit;
    logic [NREQ-1:0] sel_onehot;
    logic [7:0]      cfg_arr [NREQ];
    logic [7:0]      tx_arr  [NREQ];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_reg, tmo_next;
    logic        timed_out;
    logic        err_reg;
`endif

    // Unpack the flat per-requester buses and build the one-hot form of the selection
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign cfg_arr[gi]    = req_cfg[8*gi +: 8];
            assign tx_arr[gi]     = req_txdata[8*gi +: 8];
            assign sel_onehot[gi] = (sel_idx == IW'(gi));
        end
    endgenerate

    // Round-robin pick: first set request at or above the pointer, wrapping modulo NREQ.
    // The loop walks down, so the smallest offset from the pointer is written last and wins.
    always_comb begin
        int pos;
        pos     = 0;
        sel_idx = '0;
        sel_hit = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr_reg) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req[pos]) begin
                sel_idx = IW'(pos);
                sel_hit = 1'b1;
            end
        end
    end

    // Sequencer next-state and settle countdown
    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
`ifdef SPI_ARB_TIMEOUT_EN
        timed_out   = 1'b0;
`endif
        case (state_reg)
            S_IDLE:   if (sel_hit) state_next = S_WCTL;
            S_WCTL:   state_next = S_WTX;
            S_WTX: begin
                state_next  = S_SETTLE;
                settle_next = CW'(SETTLE_CYC - 1);
            end
            S_SETTLE: begin
                if (settle_reg == '0) begin
                    state_next = S_PRD1;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            S_PRD1:   state_next = S_PRD2;
            S_PRD2:   state_next = bus_rdata[0] ? S_RRD1 : S_PGAP;
            S_PGAP:   state_next = S_PRD1;
            S_RRD1:   state_next = S_RRD2;
            S_RRD2:   state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        // The poll budget is exhausted on the TIMEOUT_CYC-th cycle in the poll loop
        if ((state_reg == S_PRD1 || state_reg == S_PRD2 || state_reg == S_PGAP) &&
            tmo_reg == TMO_LAST) begin
            state_next = S_DONE;
            timed_out  = 1'b1;
        end
`endif
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Poll-cycle counter: zero while settling, counts each cycle of the poll loop
    always_comb begin
        tmo_next = tmo_reg;
        if (state_reg == S_SETTLE) begin
            tmo_next = '0;
        end else if (state_reg == S_PRD1 || state_reg == S_PRD2 || state_reg == S_PGAP) begin
            tmo_next = tmo_reg + 16'd1;
        end
    end
`endif

    // Bus strobes decoded from the upcoming state, so the outputs come straight from flops
    always_comb begin
        cs_next    = 1'b0;
        wr_next    = 1'b0;
        rd_next    = 1'b0;
        addr_next  = 2'b00;
        wdata_next = 8'h00;
        case (state_next)
            S_WCTL: begin
                cs_next    = 1'b1;
                wr_next    = 1'b1;
                addr_next  = 2'b00;
                wdata_next = cfg_arr[sel_idx];   // WCTL is entered only from IDLE
            end
            S_WTX: begin
                cs_next    = 1'b1;
                wr_next    = 1'b1;
                addr_next  = 2'b10;
                wdata_next = tx_reg;
            end
            S_PRD1, S_PRD2: begin
                cs_next   = 1'b1;
                rd_next   = 1'b1;
                addr_next = 2'b01;
            end
            S_RRD1, S_RRD2: begin
                cs_next   = 1'b1;
                rd_next   = 1'b1;
                addr_next = 2'b11;
            end
            default: ;
        endcase
    end

    // State, grant, pointer and registered outputs
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            settle_reg <= '0;
            ptr_reg    <= '0;
            idx_reg    <= '0;
            tx_reg     <= 8'h00;
            gnt_reg    <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            rxdata_reg <= 8'h00;
            cs_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            rd_reg     <= 1'b0;
            addr_reg   <= 2'b00;
            wdata_reg  <= 8'h00;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
            done_reg   <= (state_next == S_DONE);
            busy_reg   <= (state_next != S_IDLE);
            cs_reg     <= cs_next;
            wr_reg     <= wr_next;
            rd_reg     <= rd_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            if (state_reg == S_IDLE && sel_hit) begin
                idx_reg <= sel_idx;
                tx_reg  <= tx_arr[sel_idx];
                gnt_reg <= sel_onehot;
            end
            if (state_reg == S_RRD2) begin
                rxdata_reg <= bus_rdata;
            end
            if (state_reg == S_DONE) begin
                gnt_reg <= '0;
                ptr_reg <= (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout counter and the err pulse that accompanies an aborted done
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            tmo_reg <= tmo_next;
            err_reg <= timed_out;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign rxdata    = rxdata_reg;
    assign busy      = busy_reg;
    assign CS        = cs_reg;
    assign WR        = wr_reg;
    assign RD        = rd_reg;
    assign addr      = addr_reg;
    assign bus_wdata = wdata_reg;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter
// Scoreboard bench for spi_master_arbiter. A small SPI_Master register model answers
// the host bus. Stimulus pushes the expected bus writes and done results. A monitor
// pops and compares them whenever the DUT writes or pulses done.
// The timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_master_arbiter;

    localparam int NREQ        = 4;
    localparam int SETTLE_CYC  = 3;
    localparam int TIMEOUT_CYC = 16;

    logic              pro_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [8*NREQ-1:0] req_cfg    = '0;
    logic [8*NREQ-1:0] req_txdata = '0;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [7:0]        rxdata;
    logic              err;
    logic              busy;
    logic              CS, WR, RD;
    logic [1:0]        addr;
    logic [7:0]        bus_wdata;
    logic [7:0]        bus_rdata;

    spi_master_arbiter #(
        .NREQ(NREQ), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .pro_clk(pro_clk), .rst_n(rst_n), .req(req), .req_cfg(req_cfg),
        .req_txdata(req_txdata), .gnt(gnt), .done(done), .rxdata(rxdata),
        .err(err), .busy(busy), .CS(CS), .WR(WR), .RD(RD), .addr(addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 pro_clk = ~pro_clk;

    // ---------------- SPI_Master register model ----------------
    logic       status_bit;
    int         busy_cnt;
    logic [7:0] rx_model, tx_last, cfg_last;
    bit         loopback   = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    bit         stuck_zero = 1'b0;
    int         poll_reads = 0;

    // A txdata write starts a transfer. Divider 0 finishes almost at once; others take 16*(div+1) cycles.
    always @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            status_bit <= 1'b1;
            busy_cnt   <= 0;
            rx_model   <= 8'h00;
            tx_last    <= 8'h00;
            cfg_last   <= 8'h00;
        end else begin
            if (CS && WR && addr == 2'b00) cfg_last <= bus_wdata;
            if (CS && WR && addr == 2'b10) begin
                status_bit <= 1'b0;
                tx_last    <= bus_wdata;
                busy_cnt   <= (cfg_last[2:0] == 3'd0) ? 1 : 16 * (int'(cfg_last[2:0]) + 1);
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    status_bit <= 1'b1;
                    rx_model   <= loopback ? tx_last : slave_byte;
                end
            end
        end
    end

    always_comb begin
        bus_rdata = 8'h00;
        if (CS && RD) begin
            if (addr == 2'b01) bus_rdata = {7'b0, status_bit & ~stuck_zero};
            else if (addr == 2'b11) bus_rdata = rx_model;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [7:0]      rx;
        logic            err;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] wr_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic set_line(input int gi, input logic [7:0] c, input logic [7:0] t);
        req_cfg[8*gi +: 8]    = c;
        req_txdata[8*gi +: 8] = t;
    endtask

    // Expect the two writes of requester gi and, optionally, its done result
    task automatic push_xact(input int gi, input bit expect_done,
                             input logic [7:0] rx_exp, input logic err_exp);
        exp_t e;
        wr_q.push_back({2'b00, req_cfg[8*gi +: 8]});
        wr_q.push_back({2'b10, req_txdata[8*gi +: 8]});
        if (expect_done) begin
            e     = '0;
            e.gnt = '0;
            e.gnt[gi] = 1'b1;
            e.rx  = rx_exp;
            e.err = err_exp;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares bus writes and done results against the queues
    bit after_done = 1'b0;
    always @(negedge pro_clk) begin
        exp_t       e;
        logic [9:0] w;
        if (rst_n) begin
            if (after_done) begin
                check("gnt_drop_after_done", 32'(gnt), 32'd0);
                check("done_one_cycle", 32'(done), 32'd0);
                after_done = 1'b0;
            end
            if (CS && RD && addr == 2'b01) poll_reads++;
            if (CS && WR) begin
                check("write_expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    check("bus_write", 32'({addr, bus_wdata}), 32'(w));
                end
            end
            if (done) begin
                $display("done gnt=%b rxdata=%02h err=%0d", gnt, rxdata, err);
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("done_gnt", 32'(gnt), 32'(e.gnt));
                    check("done_rxdata", 32'(rxdata), 32'(e.rx));
                    check("done_err", 32'(err), 32'(e.err));
                    if (!e.err) check("xfer_complete", 32'(busy_cnt), 32'd0);
                end
                after_done = 1'b1;
            end
        end
    end

    // Wait for the next done; lat is inclusive of the IDLE and DONE cycles
    task automatic wait_done(input int maxcyc, output int lat);
        int n;
        n = 0;
        lat = 0;
        while (1) begin
            @(posedge pro_clk);
            #1;
            n++;
            if (done) begin
                lat = n + 1;
                break;
            end
            if (n >= maxcyc) begin
                checks++;
                errors++;
                $display("FAIL done_within_bound actual=no done in %0d cycles required=done", maxcyc);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=sim still running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  lat;
        bit  found;

        repeat (3) @(negedge pro_clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_strobes", 32'({done, err, busy, CS, WR, RD}), 32'd0);
        check("rst_bus", 32'({addr, bus_wdata, rxdata}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge pro_clk);

        // Single request, loopback, minimum latency
        set_line(0, 8'h00, 8'hA5);
        push_xact(0, 1'b1, 8'hA5, 1'b0);
        req = 4'b0001;
        wait_done(100, lat);
        req = 4'b0000;
        check("single_latency", 32'(lat), 32'd11);
        repeat (3) @(negedge pro_clk);

        // All four requesting from a fresh pointer: order 0,1,2,3,0
        rst_n = 1'b0;
        repeat (2) @(negedge pro_clk);
        rst_n = 1'b1;
        @(negedge pro_clk);
        set_line(0, 8'h00, 8'h11);
        set_line(1, 8'h00, 8'h22);
        set_line(2, 8'h00, 8'h33);
        set_line(3, 8'h00, 8'h44);
        push_xact(0, 1'b1, 8'h11, 1'b0);
        push_xact(1, 1'b1, 8'h22, 1'b0);
        push_xact(2, 1'b1, 8'h33, 1'b0);
        push_xact(3, 1'b1, 8'h44, 1'b0);
        push_xact(0, 1'b1, 8'h11, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(100, lat);
        end
        req = 4'b0000;
        repeat (3) @(negedge pro_clk);

        // Pointer wrap: grant 3, then req=1001 gives 0 then 3
        push_xact(3, 1'b1, 8'h44, 1'b0);
        req = 4'b1000;
        wait_done(100, lat);
        req = 4'b0000;
        repeat (3) @(negedge pro_clk);
        push_xact(0, 1'b1, 8'h11, 1'b0);
        push_xact(3, 1'b1, 8'h44, 1'b0);
        req = 4'b1001;
        wait_done(100, lat);
        req = 4'b1000;
        wait_done(100, lat);
        req = 4'b0000;
        repeat (3) @(negedge pro_clk);

        // Slow SPI, divider 7, slave answers 3C
        loopback   = 1'b0;
        slave_byte = 8'h3C;
        set_line(2, 8'h07, 8'h5A);
        push_xact(2, 1'b1, 8'h3C, 1'b0);
        poll_reads = 0;
        req = 4'b0100;
        wait_done(1000, lat);
        req = 4'b0000;
        check("slow_repolled", 32'(poll_reads > 2), 32'd1);
        check("slow_latency_long", 32'(lat > 128), 32'd1);
        repeat (3) @(negedge pro_clk);

        // Reset during PRD2, then re-arbitration from index 0
        set_line(1, 8'h07, 8'h77);
        push_xact(1, 1'b0, 8'h00, 1'b0);
        req = 4'b0010;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pro_clk);
            if (CS && RD && addr == 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_poll", 32'(found), 32'd1);
        @(posedge pro_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cs_rd", 32'({CS, RD, WR}), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_done_busy", 32'({done, busy}), 32'd0);
        loopback = 1'b1;
        set_line(1, 8'h00, 8'h66);
        req = 4'b1010;
        repeat (2) @(negedge pro_clk);
        rst_n = 1'b1;
        push_xact(1, 1'b1, 8'h66, 1'b0);
        push_xact(3, 1'b1, 8'h44, 1'b0);
        wait_done(100, lat);
        req = 4'b1000;
        wait_done(100, lat);
        req = 4'b0000;
        repeat (3) @(negedge pro_clk);

`ifdef SPI_ARB_TIMEOUT_EN
        // Status stuck at 0: abort after TIMEOUT_CYC poll cycles, rxdata keeps 44
        stuck_zero = 1'b1;
        set_line(0, 8'h00, 8'h99);
        push_xact(0, 1'b1, 8'h44, 1'b1);
        req = 4'b0001;
        wait_done(200, lat);
        req = 4'b0000;
        check("timeout_latency", 32'(lat), 32'd23);
        stuck_zero = 1'b0;
        repeat (3) @(negedge pro_clk);
`endif

        repeat (5) @(negedge pro_clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one SPI_Master host-bus port among NREQ requesters. It drives the SPI_Master processor interface (CS/WR/RD/addr/data) for each one-byte transfer: program control, load txdata, poll status, read rxdata. The received byte is returned to the granted requester. It sits between the requesting engines and SPI_Master, in the pro_clk domain.

Parameters:
NREQ, 4, number of requesters (2..8)
SETTLE_CYC, 3, idle cycles after the txdata write before the first status poll (must be >= 2)
TIMEOUT_CYC, 4096, poll-cycle limit (used only with the optional feature)

Ports:
pro_clk  in  1  host clock; the only clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester transfer request; level, held until done
req_cfg  in  8*NREQ  per-requester control byte: [7:5] slave select, [4] CPHA, [3] CPOL, [2:0] divider
req_txdata  in  8*NREQ  per-requester byte to send
gnt  out  NREQ  one-hot grant, held for the whole transaction
done  out  1  one-cycle pulse; the transaction for gnt is complete
rxdata  out  8  received byte, valid when done=1, held until the next done
err  out  1  one-cycle pulse with done on a timeout abort (0 without the feature)
busy  out  1  high in any state other than IDLE
CS  out  1  SPI_Master chip select
WR  out  1  SPI_Master write enable
RD  out  1  SPI_Master read enable
addr  out  2  SPI_Master register address: 00 ctrl, 01 status, 10 txdata, 11 rxdata
bus_wdata  out  8  write data; top level drives data_bus when WR=1
bus_rdata  in  8  data_bus sampled value

Behaviour:
- Reset (async, rst_n=0): state IDLE; gnt=0, done=0, err=0, busy=0, CS=WR=RD=0, addr=00, bus_wdata=0, rxdata=0, RR pointer=0.
- All outputs are registered. CS=1 only in the WCTL, WTX, PRD* and RRD* states.
- IDLE: if req!=0, select the first set bit searching upward from the pointer, wrapping modulo NREQ. Latch its index, cfg and txdata. Set gnt one-hot and go to WCTL. If req=0, stay in IDLE.
- WCTL (1 cycle): CS=1, WR=1, addr=00, bus_wdata=cfg.
- WTX (1 cycle): CS=1, WR=1, addr=10, bus_wdata=txdata. This triggers spi_word_send in SPI_Master.
- SETTLE (SETTLE_CYC cycles, counter): bus idle. Covers the registered spi_word_send and the clearing of status[0].
- PRD1 then PRD2: CS=1, RD=1, addr=01 in both cycles. Sample bus_rdata[0] at the end of PRD2. If 1, go to RRD1. If 0, go to PGAP (1 idle cycle), then back to PRD1.
- RRD1 then RRD2: CS=1, RD=1, addr=11. Latch bus_rdata into rxdata at the end of RRD2.
- DONE (1 cycle): done=1, and gnt stays asserted in this cycle. Pointer becomes (index+1) mod NREQ. Next cycle: gnt=0 and the state returns to IDLE; no back-to-back grant without passing through IDLE.
- Minimum latency, from req seen in IDLE to the done pulse: 1+1+1+SETTLE_CYC+2+2+1 cycles, which is 11 with the default.
- Lines changing mid-transaction:
  - req deassert: ignored; the transaction completes and done still pulses.
  - req_cfg/req_txdata changes: ignored, since both are latched in IDLE.
- Arbitration scope: req from other requesters has no effect until IDLE.
- rst_n asserted mid-transaction: immediate return to IDLE, all bus strobes drop asynchronously, and no done pulse is issued.
- NREQ=1: the pointer stays 0.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to PRD1 from SETTLE and increments every cycle spent in PRD1/PRD2/PGAP. On reaching TIMEOUT_CYC, the next state is DONE with err=1 and done=1, and rxdata is unchanged. The pointer advances normally.
- Undefined: no counter; polling is unbounded; err is tied to 0.

Test Plan:
- Single request: req=0001, cfg=8'h00, tx=8'hA5, slave loopback miso=mosi -> bus trace WR@00=00, WR@10=A5; done after >=11 cycles; rxdata=8'hA5; gnt=0001 until the done cycle.
- All four requesting: req=1111 held -> grant order 0,1,2,3,0; each requester is granted once per four dones; a done is never followed by a gnt change in the same cycle.
- Pointer wrap: the last grant was 3, then req=1001 -> grant 0, then grant 3.
- Slow SPI, divider=7: at least one poll returns status=0 and PGAP is repeated; done occurs only after the 8th sclk edge completes; rxdata matches the slave byte 8'h3C.
- Reset mid-poll: rst_n=0 during PRD2 -> CS/RD low immediately; gnt=0; no done; after release, a pending req is re-arbitrated starting from index 0.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, and status forced to 0 -> done=1 and err=1 after 16 poll cycles; rxdata keeps its previous value.
